vxe_vpu_stor_eu_wc: RTL

Parametrised store execution unit for the VxE vector processing unit. On a start pulse from the VPU control unit, it snapshots the per-thread store enables and issues one LSU write request per enabled thread, merging even/odd thread pairs that target the two halves of the same 64-bit word. Requests are queued in a configurable FIFO and sent through a registered valid/ready port to the LSU. It replaces the fixed 8-thread store unit, adds single-cycle skipping of disabled threads, and makes write-combine rules exact.

---
 rtl/vxe_vpu_stor_pkg.sv | 30 +++
 rtl/vxe_vpu_stor_eu_wc_if.sv | 16 +
 rtl/vxe_vpu_wrq_fifo.sv | 41 ++++
 rtl/vxe_vpu_stor_eu_wc.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vxe_vpu_stor_pkg.sv
// Shared types and constants for the VxE VPU store execution unit.
package vxe_vpu_stor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int ADDR_W = 37;
    localparam int RD_W   = 38;
    localparam int ACC_W  = 32;

    localparam logic [1:0] WEN_LO   = 2'b01;
    localparam logic [1:0] WEN_HI   = 2'b10;
    localparam logic [1:0] WEN_BOTH = 2'b11;

    // Request payload without the thread id; the id width follows NTHREADS
    // and is carried next to this struct.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [1:0]         wen;
        logic [2*ACC_W-1:0] data;
    } wrq_body_t;

    // Place a 32-bit value in the half selected by the word-address LSB.
    function automatic logic [2*ACC_W-1:0] half_place(input logic hi, input logic [ACC_W-1:0] v);
        return hi ? {v, {ACC_W{1'b0}}} : {{ACC_W{1'b0}}, v};
    endfunction

endpackage

// File: rtl/vxe_vpu_stor_eu_wc_if.sv
// LSU write-request port: registered valid/ready with thread id, word address,
// half-word enables and 64-bit data.
interface vxe_vpu_stor_eu_wc_if #(parameter int TH_W = 3);
    import vxe_vpu_stor_pkg::*;

    logic               wr;
    logic               rdy;
    logic [TH_W-1:0]    th;
    logic [ADDR_W-1:0]  addr;
    logic [1:0]         wen;
    logic [2*ACC_W-1:0] data;

    modport master (output wr, th, addr, wen, data, input rdy);
    modport slave  (input wr, th, addr, wen, data, output rdy);

endinterface

// File: rtl/vxe_vpu_wrq_fifo.sv
// Synchronous FIFO for LSU write requests. Pointers carry a wrap bit so full
// and empty are distinguished without a counter. Storage is not reset.
module vxe_vpu_wrq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    // Pointer update; full/empty are evaluated on the pre-edge pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end

    // Data write, no reset needed.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/vxe_vpu_stor_eu_wc.sv
// Store execution unit: snapshots thread enables on i_start and queues one LSU
// write per enabled thread, lowest thread first, one per cycle.
// Define VXE_VPU_STOR_WC_EN to merge an even/odd thread pair writing opposite
// halves of the same 64-bit word into a single request.
module vxe_vpu_stor_eu_wc
    import vxe_vpu_stor_pkg::*;
#(
    parameter int NTHREADS   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TH_W       = $clog2(NTHREADS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    output logic                      o_busy,
    input  logic [ACC_W*NTHREADS-1:0] i_th_acc,
    input  logic [NTHREADS-1:0]       i_th_en,
    input  logic [RD_W*NTHREADS-1:0]  i_th_rd,
    vxe_vpu_stor_eu_wc_if.master      lsu
);
    localparam int FW = TH_W + $bits(wrq_body_t);

    state_e              state, state_nxt;
    logic [NTHREADS-1:0] pend, pend_nxt;
    logic [TH_W-1:0]     t;
    logic [RD_W-1:0]     rd_t;
    logic [ACC_W-1:0]    acc_t;
    wrq_body_t           ent, head;
    logic [TH_W-1:0]     head_th;
    logic [FW-1:0]       fifo_wd, fifo_rd;
    logic                push, pop, full, empty;

    // Lowest pending thread; disabled threads are skipped in zero cycles.
    always_comb begin
        t = '0;
        for (int i = NTHREADS-1; i >= 0; i--)
            if (pend[i]) t = TH_W'(i);
    end

    assign rd_t  = i_th_rd[RD_W*t +: RD_W];
    assign acc_t = i_th_acc[ACC_W*t +: ACC_W];

`ifdef VXE_VPU_STOR_WC_EN
    logic [TH_W-1:0]  t1;
    logic [RD_W-1:0]  rd_t1;
    logic [ACC_W-1:0] acc_t1;
    logic             comb;

    assign t1     = t | TH_W'(1);
    assign rd_t1  = i_th_rd[RD_W*t1 +: RD_W];
    assign acc_t1 = i_th_acc[ACC_W*t1 +: ACC_W];
    // Pair only when the partner is pending, same word, opposite halves.
    assign comb   = !t[0] && pend[t1] &&
                    (rd_t[RD_W-1:1] == rd_t1[RD_W-1:1]) && (rd_t[0] != rd_t1[0]);
`endif

    // Build the FIFO entry for thread t (merged with t+1 when combining).
    always_comb begin
        ent.addr = rd_t[RD_W-1:1];
        ent.wen  = rd_t[0] ? WEN_HI : WEN_LO;
        ent.data = half_place(rd_t[0], acc_t);
`ifdef VXE_VPU_STOR_WC_EN
        if (comb) begin
            ent.wen  = WEN_BOTH;
            ent.data = half_place(rd_t[0], acc_t) | half_place(rd_t1[0], acc_t1);
        end
`endif
    end

    assign push    = (state == RUN) && !full;
    assign pop     = !empty && (!lsu.wr || lsu.rdy);
    assign fifo_wd = {t, ent};
    assign {head_th, head} = fifo_rd;

    vxe_vpu_wrq_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wd),
        .pop   (pop),
        .rdata (fifo_rd),
        .full  (full),
        .empty (empty)
    );

    // State and pending-mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Next state: snapshot enables on start, retire threads as entries are pushed.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        case (state)
            IDLE: begin
                if (i_start) begin
                    pend_nxt = i_th_en;
                    if (i_th_en != '0) state_nxt = RUN;
                end
            end
            RUN: begin
                if (push) begin
                    pend_nxt[t] = 1'b0;
`ifdef VXE_VPU_STOR_WC_EN
                    if (comb) pend_nxt[t1] = 1'b0;
`endif
                end
                if (pend_nxt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register: refill from the FIFO head whenever the slot is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu.wr   <= 1'b0;
            lsu.th   <= '0;
            lsu.addr <= '0;
            lsu.wen  <= '0;
            lsu.data <= '0;
        end else if (pop) begin
            lsu.wr   <= 1'b1;
            lsu.th   <= head_th;
            lsu.addr <= head.addr;
            lsu.wen  <= head.wen;
            lsu.data <= head.data;
        end else if (lsu.rdy) begin
            lsu.wr   <= 1'b0;
        end
    end

    assign o_busy = (state == RUN) || !empty || lsu.wr;

endmodule
